// File: rtl/uart_stream_ctl.sv
`default_nettype none
// ============================================================================
// Module   : uart_stream_ctl
// Purpose  : UART stream controller. It sends a writable message buffer on
//            demand and echoes received bytes through a FIFO, formatted as
//            raw, uppercase or hex.
// Revision : 1.0 - initial release
// ============================================================================
module uart_stream_ctl #(
    parameter int MSG_DEPTH  = 16,
    parameter int MSG_AW     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              tx_rdy,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic [1:0]        mode,
    input  logic              msg_we,
    input  logic [MSG_AW-1:0] msg_addr,
    input  logic [7:0]        msg_wdata,
    input  logic [MSG_AW:0]   msg_len,
    input  logic              msg_go,
    output logic              msg_busy,
    output logic [FIFO_AW:0]  fifo_cnt,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam logic [MSG_AW:0]  c_msg_depth  = (MSG_AW+1)'(MSG_DEPTH);
    localparam logic [FIFO_AW:0] c_fifo_depth = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [1:0]       c_mode_upper = 2'd1;
    localparam logic [1:0]       c_mode_hex   = 2'd2;
    localparam logic [1:0]       c_mode_off   = 2'd3;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        LOAD = 2'd1,
        REQ  = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_src_msg;
    logic               r_pending;
    logic [MSG_AW:0]    r_len;
    logic [MSG_AW:0]    r_idx;
    logic [7:0]         r_hold;
    logic [1:0]         r_hmode;
    logic [1:0]         r_sub;
    logic               r_rx_q;
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;

    logic [7:0] msg_mem  [MSG_DEPTH];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_start_msg;
    logic            w_drop_pend;
    logic            w_ovf_set;
    logic [MSG_AW:0] w_len_clamped;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign w_push_req    = rx_rdy && !r_rx_q && (mode != c_mode_off);
    assign w_start_msg   = (r_state == ARB) && r_pending && (msg_len != '0);
    assign w_drop_pend   = (r_state == ARB) && r_pending && (msg_len == '0);
    assign w_pop         = (r_state == ARB) && !w_start_msg && (fifo_cnt != '0);
    assign w_push        = w_push_req && ((fifo_cnt < c_fifo_depth) || w_pop);
    assign w_ovf_set     = w_push_req && !w_push;
    assign w_len_clamped = (msg_len > c_msg_depth) ? c_msg_depth : msg_len;
    assign msg_busy      = r_pending || (r_src_msg && (r_state != ARB));

    // Storage arrays carry no reset; contents are only meaningful once written.
    always_ff @(posedge clk_50m) begin
        if (msg_we && !msg_busy && ({1'b0, msg_addr} < c_msg_depth))
            msg_mem[msg_addr] <= msg_wdata;
        if (w_push)
            fifo_mem[r_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_rx_q   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            fifo_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            r_rx_q <= rx_rdy;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (w_ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state   <= ARB;
            r_src_msg <= 1'b0;
            r_pending <= 1'b0;
            r_len     <= '0;
            r_idx     <= '0;
            r_hold    <= '0;
            r_hmode   <= '0;
            r_sub     <= '0;
            tx_en     <= 1'b0;
            tx_data   <= '0;
        end else begin
            // A go arriving in the same cycle a send starts is kept as a resend.
            if (msg_go)
                r_pending <= 1'b1;
            else if (w_start_msg || w_drop_pend)
                r_pending <= 1'b0;

            case (r_state)
                ARB: begin
                    if (w_start_msg) begin
                        r_len     <= w_len_clamped;
                        r_idx     <= '0;
                        r_src_msg <= 1'b1;
                        r_state   <= LOAD;
                    end else if (w_pop) begin
                        r_hold    <= fifo_mem[r_rd_ptr];
                        r_hmode   <= mode;
                        r_sub     <= '0;
                        r_src_msg <= 1'b0;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (r_src_msg)
                        tx_data <= msg_mem[r_idx[MSG_AW-1:0]];
                    else if (r_hmode == c_mode_upper)
                        tx_data <= ((r_hold >= 8'h61) && (r_hold <= 8'h7A)) ? (r_hold - 8'd32) : r_hold;
                    else if (r_hmode == c_mode_hex)
                        tx_data <= (r_sub == 2'd0) ? hex_char(r_hold[7:4]) :
                                   (r_sub == 2'd1) ? hex_char(r_hold[3:0]) : 8'h20;
                    else
                        tx_data <= r_hold;
                    r_state <= REQ;
                end
                REQ: begin
                    if (tx_rdy) begin
                        tx_en   <= 1'b1;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    if (!tx_rdy) begin
                        tx_en <= 1'b0;
                        if (r_src_msg) begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ((r_idx + 1'b1) == r_len) ? ARB : LOAD;
                        end else if ((r_hmode == c_mode_hex) && (r_sub != 2'd2)) begin
                            r_sub   <= r_sub + 1'b1;
                            r_state <= LOAD;
                        end else begin
                            r_state <= ARB;
                        end
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

endmodule
`default_nettype wire
